uart_tx_byte: RTL and testbench
===============================

// Module: uart_tx_byte
//
// PURPOSE
// Serial byte transmitter: frames 8-bit values (e.g. the 8-bit counter value) as
// 8N1/8E1 async UART on one output pin, for logging sequential-demo state to a host.
// Sits downstream of the counter / top-level datapath and consumes a byte through a
// valid/ready handshake. Its tx pin drives the board UART pin.
//
// PARAMETERS
// CLK_HZ      27000000  input clock frequency in Hz
// BAUD        115200    line rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer division, 234 at defaults)
// PARITY_EN   0         1 = append even-parity bit after the data bits
// STOP_BITS   1         number of stop bits, 1 or 2
//
// PORTS
// clk        in   1  system clock, all logic on posedge
// rst_n      in   1  synchronous active-low reset
// tx_data    in   8  byte to send, sampled only on handshake
// tx_valid   in   1  upstream has a byte available
// tx_ready   out  1  block can accept a byte (high only in IDLE)
// tx         out  1  serial line, idle high
// busy       out  1  frame in progress (any state other than IDLE)
// tx_done    out  1  one-cycle pulse in the final cycle of the last stop bit
//
// BEHAVIOUR
// - Reset: every posedge with rst_n=0 forces state=IDLE, tx=1, busy=0, tx_done=0,
//   bit/baud counters=0. tx_ready=1 from the first edge after reset is applied.
// - Reset mid-frame abandons the frame: tx=1 at that edge, and no tx_done pulse.
// - Handshake: byte accepted at an edge where tx_valid && tx_ready.
//   tx_data is latched into the shift register at that edge.
//   tx_ready and busy change on that same edge (tx_ready=0, busy=1).
//   tx_data and tx_valid changes while busy are ignored.
// - FSM: IDLE -> START -> DATA(8 bits) -> [PARITY if PARITY_EN] -> STOP(STOP_BITS) -> IDLE.
// - Every bit is held for exactly CLKS_PER_BIT cycles by a baud counter 0..CLKS_PER_BIT-1.
//   Counter width is $clog2(CLKS_PER_BIT).
// - START drives tx=0. DATA shifts LSB first. PARITY drives ^data (even parity). STOP drives tx=1.
// - Timing: tx falls in the cycle after the accept edge.
//   Frame length = (1+8+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles.
// - tx_done=1 during the last cycle of the last stop bit.
//   The same edge returns the FSM to IDLE; tx_ready=1 the next cycle.
// - Back-to-back: if tx_valid is held, the next byte is accepted the first IDLE cycle.
//   The next start bit then follows the stop bit(s) with exactly one extra idle-high cycle.
// - tx is a registered output, so the pin is glitch-free.
// - Elaboration error if CLKS_PER_BIT < 2 or STOP_BITS is not in {1,2}.
//
// TESTING (sim params CLK_HZ=1000, BAUD=100 -> CLKS_PER_BIT=10)
// - Reset: hold rst_n=0 3 cycles -> tx=1, busy=0, tx_done=0; tx_ready=1 after reset edge.
// - Single byte 0xA5, 8N1: accept at edge N -> tx=0 cycles N+1..N+10;
//   data 1,0,1,0,0,1,0,1 in 10-cycle slots; stop=1; tx_done at N+100; tx_ready=1 at N+101.
// - PARITY_EN=1, STOP_BITS=2, byte 0x07 -> parity bit=1; frame 120 cycles; tx_done once.
// - Back-to-back 0x00 then 0xFF with tx_valid held -> second start bit begins 1 cycle after
//   the first frame's last stop cycle; both frames decoded correctly by the bench UART model.
// - tx_data toggled every cycle while busy -> transmitted bits match the byte latched at accept.
// - rst_n=0 for 1 cycle during bit 4 of 0x3C -> tx=1 next edge, no tx_done;
//   next byte 0x55 is sent cleanly.

Source files
------------

// File: rtl/uart_tx_byte.sv
// Byte-wide async serial transmitter (8N1 / 8E1, 1 or 2 stop bits) with a
// valid/ready input handshake and a registered, idle-high tx pin.
module uart_tx_byte #(
  parameter int CLK_HZ    = 27000000,
  parameter int BAUD      = 115200,
  parameter int PARITY_EN = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx_byte: CLK_HZ/BAUD must be at least 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_byte: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           state_q, state_n;
  logic [CNT_W-1:0] baud_q, baud_n;
  logic [2:0]       bit_q, bit_n;
  logic [7:0]       shreg_q, shreg_n;
  logic             par_q, par_n;
  logic             tx_q, tx_n;
  logic             baud_tick;

  assign baud_tick = (baud_q == BAUD_LAST);

  always_comb begin
    // NOTE: every next-state variable gets its hold value first, so no path
    // through the case below can leave one unassigned and infer a latch.
    state_n = state_q;
    baud_n  = baud_q;
    bit_n   = bit_q;
    shreg_n = shreg_q;
    par_n   = par_q;

    if (state_q != S_IDLE) begin
      baud_n = baud_tick ? '0 : baud_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          state_n = S_START;
          shreg_n = tx_data;
          par_n   = ^tx_data;
          baud_n  = '0;
          bit_n   = '0;
        end
      end
      S_START: begin
        if (baud_tick) begin
          state_n = S_DATA;
          bit_n   = '0;
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          shreg_n = {1'b0, shreg_q[7:1]};
          if (bit_q == 3'd7) begin
            state_n = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            bit_n   = '0;
          end else begin
            bit_n = bit_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (baud_tick) begin
          state_n = S_STOP;
          bit_n   = '0;
        end
      end
      S_STOP: begin
        if (baud_tick) begin
          if (bit_q == STOP_LAST) begin
            state_n = S_IDLE;
          end else begin
            bit_n = bit_q + 3'd1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    // The pin level is derived from the state being entered, so it can be
    // registered alongside the state and still line up with each bit slot.
    case (state_n)
      S_START:  tx_n = 1'b0;
      S_DATA:   tx_n = shreg_n[0];
      S_PARITY: tx_n = par_n;
      default:  tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_n;
      baud_q  <= baud_n;
      bit_q   <= bit_n;
      shreg_q <= shreg_n;
      par_q   <= par_n;
      tx_q    <= tx_n;
    end
  end

  assign tx       = tx_q;
  assign tx_ready = (state_q == S_IDLE);
  assign busy     = (state_q != S_IDLE);
  assign tx_done  = (state_q == S_STOP) && (bit_q == STOP_LAST) && baud_tick;

endmodule

// File: tb/tb_uart_tx_byte.sv
// Self-checking bench for uart_tx_byte: an 8N1 instance and an 8E1/2-stop
// instance, checked against a bit-slot model of the serial frame.
module tb_uart_tx_byte;

  localparam int CPB     = 10;
  localparam int FRAME_A = (1 + 8 + 0 + 1) * CPB;
  localparam int FRAME_B = (1 + 8 + 1 + 2) * CPB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       valid_a, valid_b;
  logic       ready_a, tx_a, busy_a, done_a;
  logic       ready_b, tx_b, busy_b, done_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx_byte #(.CLK_HZ(1000), .BAUD(100), .PARITY_EN(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(valid_a),
    .tx_ready(ready_a), .tx(tx_a), .busy(busy_a), .tx_done(done_a)
  );

  uart_tx_byte #(.CLK_HZ(1000), .BAUD(100), .PARITY_EN(1), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(valid_b),
    .tx_ready(ready_b), .tx(tx_b), .busy(busy_b), .tx_done(done_b)
  );

  typedef struct {
    logic [7:0] data;
    logic       exp_par;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic cur_tx(input bit use_b);
    return use_b ? tx_b : tx_a;
  endfunction
  function automatic logic cur_ready(input bit use_b);
    return use_b ? ready_b : ready_a;
  endfunction
  function automatic logic cur_busy(input bit use_b);
    return use_b ? busy_b : busy_a;
  endfunction
  function automatic logic cur_done(input bit use_b);
    return use_b ? done_b : done_a;
  endfunction

  // Line level expected in bit slot j of a frame carrying d.
  function automatic logic model_bit(input bit use_b, input logic [7:0] d, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return d[j-1];
    if (use_b && j == 9) return ^d;
    return 1'b1;
  endfunction

  // Called at a negedge. Offers d, waits for the accept, then follows the
  // whole frame cycle by cycle and decodes it at mid-bit like a host UART.
  task automatic frame(input bit use_b, input logic [7:0] d, input bit toggle,
                       input bit keep_valid, output int waited, output logic dec_par);
    int         flen;
    int         wave_err;
    int         done_cnt;
    int         done_pos;
    logic [7:0] dec;
    flen     = use_b ? FRAME_B : FRAME_A;
    wave_err = 0;
    done_cnt = 0;
    done_pos = -1;
    dec      = 'x;
    dec_par  = 1'bx;
    tx_data  = d;
    if (use_b) valid_b = 1'b1; else valid_a = 1'b1;
    waited = 0;
    while (!cur_ready(use_b) && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    check("accept_ready", cur_ready(use_b), 1'b1);
    @(posedge clk);
    @(negedge clk);
    if (!keep_valid) begin
      valid_a = 1'b0;
      valid_b = 1'b0;
    end
    check("busy_after_accept", {cur_busy(use_b), cur_ready(use_b)}, 2'b10);
    for (int k = 1; k <= flen; k++) begin
      int j;
      j = (k - 1) / CPB;
      if (toggle) tx_data = 8'($urandom);
      if (cur_tx(use_b) !== model_bit(use_b, d, j)) wave_err++;
      if (cur_done(use_b)) begin
        done_cnt++;
        done_pos = k;
      end
      if ((k - 1) % CPB == CPB / 2) begin
        if (j >= 1 && j <= 8) dec[j-1] = cur_tx(use_b);
        if (use_b && j == 9) dec_par = cur_tx(use_b);
      end
      @(negedge clk);
    end
    check("frame_waveform_errors", wave_err, 0);
    check("tx_done_count", done_cnt, 1);
    check("tx_done_position", done_pos, flen);
    check("decoded_byte", dec, d);
    check("idle_after_frame", {cur_ready(use_b), cur_tx(use_b), cur_busy(use_b)}, 3'b110);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   w;
    logic p;
    int   bad_idle;

    vecs[0] = '{8'hA5, 1'b0};
    vecs[1] = '{8'h07, 1'b1};
    vecs[2] = '{8'h00, 1'b0};
    vecs[3] = '{8'hFF, 1'b0};
    vecs[4] = '{8'h01, 1'b1};
    vecs[5] = '{8'h80, 1'b1};
    vecs[6] = '{8'h3C, 1'b0};
    vecs[7] = '{8'hFE, 1'b1};

    rst_n   = 1'b0;
    tx_data = 8'h00;
    valid_a = 1'b0;
    valid_b = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_a", {tx_a, busy_a, done_a, ready_a}, 4'b1001);
    check("reset_b", {tx_b, busy_b, done_b, ready_b}, 4'b1001);
    rst_n = 1'b1;
    @(negedge clk);

    // 8N1 single byte
    frame(1'b0, 8'hA5, 1'b0, 1'b0, w, p);

    // 8E1 with two stop bits, parity taken from the table
    for (int i = 0; i < 8; i++) begin
      frame(1'b1, vecs[i].data, 1'b0, 1'b0, w, p);
      check("parity_bit", p, vecs[i].exp_par);
    end

    // Back-to-back with tx_valid held: accepted on the first idle cycle
    frame(1'b0, 8'h00, 1'b0, 1'b1, w, p);
    frame(1'b0, 8'hFF, 1'b0, 1'b0, w, p);
    check("b2b_idle_wait", w, 0);

    // tx_data churning while busy must not leak into the frame
    frame(1'b0, 8'h96, 1'b1, 1'b0, w, p);
    frame(1'b1, 8'h69, 1'b1, 1'b0, w, p);

    // Reset during data bit 4 of 0x3C
    tx_data = 8'h3C;
    valid_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_a = 1'b0;
    repeat (54) @(negedge clk);
    check("mid_frame_bit4", tx_a, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_state", {tx_a, busy_a, ready_a, done_a}, 4'b1010);
    bad_idle = 0;
    for (int k = 0; k < FRAME_A + 10; k++) begin
      if (done_a !== 1'b0 || tx_a !== 1'b1) bad_idle++;
      @(negedge clk);
    end
    check("abort_no_done_line_idle", bad_idle, 0);
    frame(1'b0, 8'h55, 1'b0, 1'b0, w, p);

    // Randomized bytes on either instance, some with churning tx_data
    for (int i = 0; i < 6; i++) begin
      logic [7:0] d;
      bit         b;
      bit         t;
      d = 8'($urandom);
      b = 1'($urandom_range(0, 1));
      t = 1'($urandom_range(0, 1));
      frame(b, d, t, 1'b0, w, p);
      if (b) check("random_parity", p, ^d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
